ee357_mc_control: RTL and testbench
===================================

# ee357_mc_control

Multicycle control unit for the EE357 CPU datapath. A Moore state machine decodes the 6-bit opcode held in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select. This includes the 2-bit selects consumed by the 4x32 select muxes: ALU operand B select and PC source select.

## Interface
Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge
- rst_n  input  1  reset; asynchronous and active-low
- opcode  input  6  instruction register bits [31:26]
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if the ALU zero flag is set
- ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write data select: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  output  2  ALU B mux select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- alu_op  output  2  ALU control class: 00 = add, 01 = subtract, 10 = funct field
- pc_source  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  opcode not recognised while in DECODE
- state  output  4  current state encoding, for debug

## Operation
State encodings and outputs. Any output not listed for a state is 0.
- IDLE (0): all outputs 0. Next state is FETCH.
- FETCH (1): mem_read=1, alu_src_b=01. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (2): alu_src_b=11 to precompute the branch target. Next state by opcode:
  - LW or SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - any other opcode → FETCH, with illegal_op=1 for this cycle
- MEMADR (3): alu_src_a=1, alu_src_b=10. Next state is MEMRD for LW, MEMWR for SW. The opcode is re-sampled here; the IR is stable.
- MEMRD (4): mem_read=1, ior_d=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB (5): reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- MEMWR (6): mem_write=1, ior_d=1. Hold while mem_ready=0; go to FETCH when mem_ready=1.
- EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10. Next state is RTYPEWB.
- RTYPEWB (8): reg_write=1, reg_dst=1. Next state is FETCH.
- BRANCH (9): alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next state is FETCH.
- JUMP (10): pc_write=1, pc_source=10. Next state is FETCH.
- Encodings 11–15 are unreachable. If entered, the FSM goes to IDLE with all outputs 0.

## Timing
- Reset: while rst_n=0, state=IDLE and all outputs are 0, independent of clk.
- Reset asserted mid-instruction aborts immediately. No partial write or PC update is issued after the assertion.
- First FETCH is the cycle after the first rising edge following reset release.
- Outputs are combinational decodes of the state register plus mem_ready/opcode as listed above. They have no glitch requirement; they must be stable before the next rising edge.
- Cycles per instruction with mem_ready tied high: LW 5, SW 4, R-type 4, BEQ 3, J 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle. The request output stays asserted throughout the wait.
- mem_read and mem_write are never both 1. ir_write is 1 only in FETCH.

## Test plan
- Reset: pulse rst_n low mid-cycle → outputs 0 and state=0 asynchronously. After release, state sequence is 0, 1, 2.
- LW (opcode 6'h23), mem_ready=1 → states 1, 2, 3, 4, 5, 1. In state 5: reg_write=1, mem_to_reg=1, reg_dst=0.
- SW (6'h2B) with mem_ready low for 3 cycles in MEMWR → state 6 held for 4 cycles with mem_write=1 and ior_d=1, then state 1.
- R-type (6'h00) followed by BEQ (6'h04):
  - R-type → states 7, 8; alu_op=10 in 7; reg_dst=1 in 8.
  - BEQ → in state 9: pc_write_cond=1, pc_source=01, alu_op=01.
- J (6'h02) → in state 10: pc_write=1, pc_source=10. Opcode 6'h3F in DECODE → illegal_op=1 for one cycle, next state 1.
- FETCH with mem_ready=0 for 2 cycles → pc_write=0 and ir_write=0 while waiting; both 1 in the third cycle, then DECODE.

Source files
------------

// File: rtl/ee357_mc_control.sv
// Multicycle control FSM for the EE357 datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: outputs are a combinational decode of the current state (plus mem_ready/opcode); one state per clock.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR with the request still asserted.
module ee357_mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_t;

    // All datapath controls travel together so every state starts from an all-zero word.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    state_t cur_state;
    ctrl_t  ctrl;

    // State register and next-state sequencing; unused encodings fall back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE:    cur_state <= S_FETCH;
                S_FETCH:   cur_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (opcode == OP_LW || opcode == OP_SW) cur_state <= S_MEMADR;
                    else if (opcode == OP_RTYPE)            cur_state <= S_EXEC;
                    else if (opcode == OP_BEQ)              cur_state <= S_BRANCH;
                    else if (opcode == OP_J)                cur_state <= S_JUMP;
                    else                                    cur_state <= S_FETCH;
                end
                // IR is stable here, so the opcode picks the access direction again.
                S_MEMADR: begin
                    if (opcode == OP_LW)      cur_state <= S_MEMRD;
                    else if (opcode == OP_SW) cur_state <= S_MEMWR;
                    else                      cur_state <= S_FETCH;
                end
                S_MEMRD:   cur_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   cur_state <= S_FETCH;
                S_MEMWR:   cur_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:    cur_state <= S_RTYPEWB;
                S_RTYPEWB: cur_state <= S_FETCH;
                S_BRANCH:  cur_state <= S_FETCH;
                S_JUMP:    cur_state <= S_FETCH;
                default:   cur_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the control word; FETCH gates IR/PC loads on mem_ready, DECODE flags bad opcodes.
    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'b11;
                ctrl.illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                                    opcode == OP_BEQ || opcode == OP_J);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ior_d         = ctrl.ior_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = cur_state;

endmodule

// File: tb/tb_ee357_mc_control.sv
// Bench for ee357_mc_control: instruction-level reference builds the expected phase sequence per opcode.
// Latency: one check per clock, sampled 4 time units after the rising edge.
// Backpressure: mem_ready wait cycles are chosen per instruction and folded into the expected sequence.
module tb_ee357_mc_control;

    localparam logic [5:0] T_RTYPE = 6'h00;
    localparam logic [5:0] T_LW    = 6'h23;
    localparam logic [5:0] T_SW    = 6'h2B;
    localparam logic [5:0] T_BEQ   = 6'h04;
    localparam logic [5:0] T_J     = 6'h02;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4, P_MEMWB = 5;
    localparam int P_MEMWR = 6, P_EXEC = 7, P_RTYPEWB = 8, P_BRANCH = 9, P_JUMP = 10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    obs_t       got;

    int vectors = 0;
    int miscompares = 0;

    ee357_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ior_d(ior_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign got = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state};

    function automatic logic legal(input logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ || op == T_J;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word for one phase, straight from the per-state output table.
    function automatic obs_t model(input int ph, input logic mr, input logic [5:0] op);
        obs_t e;
        e = '0;
        e.state = 4'(ph);
        case (ph)
            P_FETCH:   begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            P_DECODE:  begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
            P_MEMADR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            P_MEMRD:   begin e.mem_read = 1'b1; e.ior_d = 1'b1; end
            P_MEMWB:   begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            P_MEMWR:   begin e.mem_write = 1'b1; e.ior_d = 1'b1; end
            P_EXEC:    begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            P_RTYPEWB: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            P_BRANCH:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_source = 2'b01; end
            P_JUMP:    begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
            default:   e.state = 4'd0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h (state %0d vs %0d)", tag, got, exp, got.state, exp.state);
        end
    endtask

    // One clock: drive inputs just after the edge, compare well before the next one.
    task automatic cycle(input string tag, input int ph, input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1 mem_ready = mr;
        opcode = op;
        #3 check(tag, model(ph, mr, op));
    endtask

    // Instruction-level reference: fetch (with fw waits), decode, then the opcode's own phase list.
    task automatic run(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) cycle("fetch_wait", P_FETCH, 1'b0, op);
        cycle("fetch", P_FETCH, 1'b1, op);
        cycle("decode", P_DECODE, rbit(), op);
        case (op)
            T_LW: begin
                cycle("lw_memadr", P_MEMADR, rbit(), op);
                for (int i = 0; i < mw; i++) cycle("lw_memrd_wait", P_MEMRD, 1'b0, op);
                cycle("lw_memrd", P_MEMRD, 1'b1, op);
                cycle("lw_memwb", P_MEMWB, rbit(), op);
            end
            T_SW: begin
                cycle("sw_memadr", P_MEMADR, rbit(), op);
                for (int i = 0; i < mw; i++) cycle("sw_memwr_wait", P_MEMWR, 1'b0, op);
                cycle("sw_memwr", P_MEMWR, 1'b1, op);
            end
            T_RTYPE: begin
                cycle("r_exec", P_EXEC, rbit(), op);
                cycle("r_wb", P_RTYPEWB, rbit(), op);
            end
            T_BEQ:   cycle("beq_branch", P_BRANCH, rbit(), op);
            T_J:     cycle("j_jump", P_JUMP, rbit(), op);
            default: ;
        endcase
    endtask

    // Assert reset mid-cycle, check outputs clear at once and stay clear across an edge, then release.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 check({tag, "_async"}, model(P_IDLE, 1'b0, opcode));
        @(posedge clk);
        #1 mem_ready = 1'b1;
        #1 check({tag, "_hold"}, model(P_IDLE, 1'b1, opcode));
        #2 rst_n = 1'b1;
        #1 check({tag, "_release"}, model(P_IDLE, 1'b1, opcode));
    endtask

    initial begin
        logic [5:0] kinds [5];
        logic [5:0] op;
        kinds[0] = T_RTYPE; kinds[1] = T_LW; kinds[2] = T_SW; kinds[3] = T_BEQ; kinds[4] = T_J;

        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = T_LW;
        #3 check("reset_state", model(P_IDLE, 1'b1, opcode));
        #5 rst_n = 1'b1;
        #1 check("idle_after_release", model(P_IDLE, 1'b1, opcode));

        // Directed walk through each instruction class.
        run(T_LW, 0, 0);
        run(T_SW, 0, 3);
        run(T_RTYPE, 0, 0);
        run(T_BEQ, 0, 0);
        run(T_J, 0, 0);
        run(6'h3F, 0, 0);
        run(T_LW, 2, 1);
        run(T_RTYPE, 0, 0);

        // Abort a load while waiting on memory.
        cycle("abort_fetch", P_FETCH, 1'b1, T_LW);
        cycle("abort_decode", P_DECODE, 1'b1, T_LW);
        cycle("abort_memadr", P_MEMADR, 1'b1, T_LW);
        cycle("abort_memrd", P_MEMRD, 1'b0, T_LW);
        reset_pulse("rst_in_memrd");
        run(T_BEQ, 1, 0);

        // Abort a store on the very cycle memory completes: the write request must drop.
        cycle("abort2_fetch", P_FETCH, 1'b1, T_SW);
        cycle("abort2_decode", P_DECODE, 1'b0, T_SW);
        cycle("abort2_memadr", P_MEMADR, 1'b0, T_SW);
        cycle("abort2_memwr", P_MEMWR, 1'b1, T_SW);
        reset_pulse("rst_in_memwr");

        // Random instruction mix with random memory stalls.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = kinds[$urandom_range(0, 4)];
            end
            run(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
